// File: rtl/mdio_link_monitor.sv
// MDIO master that polls the 88E1111 PHY-specific status register and
// resolves link/speed/duplex for the tx_clk selection logic.
module mdio_link_monitor #(
  parameter int unsigned CLK_DIV     = 4,
  parameter logic [4:0]  PHY_ADDR    = 5'd16,
  parameter logic [4:0]  STATUS_REG  = 5'd17,
  parameter int unsigned POLL_CYCLES = 1000000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  output logic        mdc_o,
  input  logic        mdio_in_i,
  output logic        mdio_out_o,
  output logic        mdio_oen_o,
  output logic        link_up_o,
  output logic        speed_1000_o,
  output logic        speed_10_o,
  output logic        full_duplex_o,
  output logic [15:0] status_raw_o,
  output logic        status_valid_o,
  output logic        link_change_o,
  output logic        rd_error_o
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_CYCLES - 1);
  localparam logic [13:0] CMD_WORD = {4'b0110, PHY_ADDR, STATUS_REG};

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, CMD, TA, DATA, UPDATE
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [PW-1:0] wait_q, wait_d;
  logic [5:0]    bit_q, bit_d;
  logic [15:0]   shift_q, shift_d;
  logic [15:0]   raw_q, raw_d;
  logic          mdc_q, mdc_d;
  logic          out_q, out_d;
  logic          oen_q, oen_d;
  logic          link_q, link_d;
  logic          s1000_q, s1000_d;
  logic          s10_q, s10_d;
  logic          fd_q, fd_d;
  logic          valid_q, valid_d;
  logic          chg_q, chg_d;
  logic          err_q, err_d;

  logic          busy, tick, rise, fall;
  logic [5:0]    nb;
  logic [3:0]    cmd_idx;

  assign busy    = (state_q != IDLE) && (state_q != UPDATE);
  assign tick    = (div_q == DIV_LAST);
  assign rise    = busy && tick && !mdc_q;
  assign fall    = busy && tick && mdc_q;
  assign nb      = bit_q + 6'd1;
  assign cmd_idx = 4'(6'd45 - nb);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      wait_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      raw_q   <= '0;
      mdc_q   <= 1'b0;
      out_q   <= 1'b1;
      oen_q   <= 1'b1;
      link_q  <= 1'b0;
      s1000_q <= 1'b0;
      s10_q   <= 1'b0;
      fd_q    <= 1'b0;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      wait_q  <= wait_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      raw_q   <= raw_d;
      mdc_q   <= mdc_d;
      out_q   <= out_d;
      oen_q   <= oen_d;
      link_q  <= link_d;
      s1000_q <= s1000_d;
      s10_q   <= s10_d;
      fd_q    <= fd_d;
      valid_q <= valid_d;
      chg_q   <= chg_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    wait_d  = wait_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    raw_d   = raw_q;
    mdc_d   = mdc_q;
    out_d   = out_q;
    oen_d   = oen_q;
    link_d  = link_q;
    s1000_d = s1000_q;
    s10_d   = s10_q;
    fd_d    = fd_q;
    valid_d = valid_q;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        mdc_d = 1'b0;
        div_d = '0;
        out_d = 1'b1;
        oen_d = 1'b1;
        if (wait_q != '0) begin
          wait_d = wait_q - PW'(1);
        end else if (enable_i) begin
          state_d = PREAMBLE;
          bit_d   = '0;
          oen_d   = 1'b0;
        end
      end
      PREAMBLE, CMD, TA, DATA: begin
        div_d = tick ? '0 : div_q + DW'(1);
        if (tick) mdc_d = ~mdc_q;
        if (rise) begin
          shift_d = {shift_q[14:0], mdio_in_i};
          // Second turnaround bit must be pulled low by the PHY.
          if (bit_q == 6'd47 && mdio_in_i) begin
            state_d = IDLE;
            mdc_d   = 1'b0;
            div_d   = '0;
            wait_d  = POLL_LOAD;
            err_d   = 1'b1;
            link_d  = 1'b0;
          end
        end
        if (fall) begin
          bit_d = nb;
          if (bit_q == 6'd63) begin
            state_d = UPDATE;
            out_d   = 1'b1;
            oen_d   = 1'b1;
          end else if (nb < 6'd32) begin
            state_d = PREAMBLE;
            out_d   = 1'b1;
            oen_d   = 1'b0;
          end else if (nb < 6'd46) begin
            state_d = CMD;
            out_d   = CMD_WORD[cmd_idx];
            oen_d   = 1'b0;
          end else if (nb < 6'd48) begin
            state_d = TA;
            out_d   = 1'b1;
            oen_d   = 1'b1;
          end else begin
            state_d = DATA;
            out_d   = 1'b1;
            oen_d   = 1'b1;
          end
        end
      end
      UPDATE: begin
        state_d = IDLE;
        wait_d  = POLL_LOAD;
        raw_d   = shift_q;
        valid_d = 1'b1;
        link_d  = shift_q[10];
        // Speed/duplex only trusted once the PHY reports them resolved.
        if (shift_q[11] && shift_q[15:14] != 2'b11) begin
          s1000_d = (shift_q[15:14] == 2'b10);
          s10_d   = (shift_q[15:14] == 2'b00);
          fd_d    = shift_q[13];
        end
      end
      default: state_d = IDLE;
    endcase

    chg_d = link_d ^ link_q;
  end

  assign mdc_o          = mdc_q;
  assign mdio_out_o     = out_q;
  assign mdio_oen_o     = oen_q;
  assign link_up_o      = link_q;
  assign speed_1000_o   = s1000_q;
  assign speed_10_o     = s10_q;
  assign full_duplex_o  = fd_q;
  assign status_raw_o   = raw_q;
  assign status_valid_o = valid_q;
  assign link_change_o  = chg_q;
  assign rd_error_o     = err_q;
endmodule

// File: tb/tb_mdio_link_monitor.sv
// Directed bench for mdio_link_monitor with a small
// bus-functional PHY answering status reads.
module tb_mdio_link_monitor;
  localparam int CLK_DIV = 4;
  localparam int POLL    = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic mdio_in = 1'b1;
  logic mdc, mdio_out, mdio_oen;
  logic link_up, s1000, s10, fd, valid, chg, err;
  logic [15:0] raw;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int rc = 0;
  logic [63:0] cap_out = '0;
  logic [63:0] cap_oen = '0;
  logic [15:0] phy_data = 16'h0;
  logic phy_on = 1'b1;

  mdio_link_monitor #(
    .CLK_DIV(CLK_DIV),
    .PHY_ADDR(5'd16),
    .STATUS_REG(5'd17),
    .POLL_CYCLES(POLL)
  ) dut (
    .clk_i(clk),
    .reset_i(rst),
    .enable_i(en),
    .mdc_o(mdc),
    .mdio_in_i(mdio_in),
    .mdio_out_o(mdio_out),
    .mdio_oen_o(mdio_oen),
    .link_up_o(link_up),
    .speed_1000_o(s1000),
    .speed_10_o(s10),
    .full_duplex_o(fd),
    .status_raw_o(raw),
    .status_valid_o(valid),
    .link_change_o(chg),
    .rd_error_o(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bit counter: cleared at frame start, bumped on each mdc rise.
  always @(posedge mdc or negedge mdio_oen) begin
    if (mdc) begin
      if (rc < 64) begin
        cap_out[63-rc] <= mdio_out;
        cap_oen[63-rc] <= mdio_oen;
      end
      rc <= rc + 1;
    end else begin
      rc <= 0;
    end
  end

  always @(negedge mdc) begin
    if (!phy_on) mdio_in = 1'b1;
    else if (rc == 47) mdio_in = 1'b0;
    else if (rc >= 48 && rc < 64) mdio_in = phy_data[63-rc];
    else mdio_in = 1'b1;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_start(output bit ok, output int c);
    ok = 1'b0;
    c = -1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (!mdio_oen) begin
        ok = 1'b1;
        c = cyc;
      end
    end
  endtask

  initial begin
    int c0, c1, cen, r1, r2, n;
    logic prev;
    bit ok;

    repeat (3) @(negedge clk);
    chk("rst_mdc", mdc, 0);
    chk("rst_oen", mdio_oen, 1);
    chk("rst_out", mdio_out, 1);
    chk("rst_stat", {link_up, s1000, s10, fd, raw, valid, chg, err}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_en_idle", mdio_oen, 1);

    // Frame 1: 1000/full, link up
    phy_data = 16'hAC00;
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("first_start", mdio_oen, 0);
    c0 = cyc;
    prev = mdc;
    r1 = -1;
    r2 = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mdc && !prev) begin
        if (r1 < 0) r1 = cyc;
        else if (r2 < 0) r2 = cyc;
      end
      prev = mdc;
    end
    chk("mdc_period", r2 - r1, 8);
    wait_to(c0 + 512);
    chk("pre_upd_valid", valid, 0);
    wait_to(c0 + 513);
    chk("lat_valid", valid, 1);
    chk("a_link", link_up, 1);
    chk("a_1000", s1000, 1);
    chk("a_10", s10, 0);
    chk("a_fd", fd, 1);
    chk("a_raw", raw, 16'hAC00);
    chk("a_chg", chg, 1);
    chk("fmt_out", cap_out[63:18], {32'hFFFF_FFFF, 14'b01_10_10000_10001});
    chk("fmt_oen", cap_oen, {46'h0, 18'h3FFFF});
    chk("rises", rc, 64);
    phy_data = 16'h2C00;
    @(negedge clk);
    chk("a_chg_pulse", chg, 0);

    // Frame 2: 10/full, link stays up
    wait_start(ok, c1);
    chk("f2_start", ok, 1);
    chk("poll_gap", c1 - c0, 533);
    wait_to(c1 + 513);
    chk("b_raw", raw, 16'h2C00);
    chk("b_10", s10, 1);
    chk("b_1000", s1000, 0);
    chk("b_fd", fd, 1);
    chk("b_chg", chg, 0);
    phy_data = 16'h8000;

    // Frame 3: unresolved, link down; enable dropped in preamble
    wait_start(ok, c0);
    chk("f3_start", ok, 1);
    en = 1'b0;
    wait_to(c0 + 513);
    chk("c_raw", raw, 16'h8000);
    chk("c_link", link_up, 0);
    chk("c_chg", chg, 1);
    chk("c_10_hold", s10, 1);
    chk("c_1000", s1000, 0);
    chk("c_fd_hold", fd, 1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!mdio_oen) n++;
    end
    chk("en_off_idle", n, 0);
    cen = cyc;
    en = 1'b1;
    wait_start(ok, c0);
    chk("f4_start", ok, 1);
    chk("reen_lat", c0 - cen, 1);

    // Reset in the high phase of data bit 5
    wait_to(c0 + 8 * 53 + 6);
    chk("pre_rst_mdc", mdc, 1);
    rst = 1'b1;
    #1;
    chk("mrst_mdc", mdc, 0);
    chk("mrst_oen", mdio_oen, 1);
    chk("mrst_out", mdio_out, 1);
    chk("mrst_stat", {link_up, s1000, s10, fd, raw, valid, chg, err}, 0);
    phy_on = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_restart", mdio_oen, 0);
    c0 = cyc;

    // No PHY: turnaround failure every frame
    wait_to(c0 + 379);
    chk("np_err_pre", err, 0);
    wait_to(c0 + 380);
    chk("np_err", err, 1);
    chk("np_oen", mdio_oen, 1);
    chk("np_mdc", mdc, 0);
    chk("np_link", link_up, 0);
    chk("np_valid", valid, 0);
    @(negedge clk);
    chk("np_err_pulse", err, 0);
    wait_start(ok, c1);
    chk("np_f2_start", ok, 1);
    chk("np_gap", c1 - c0, 400);
    wait_to(c1 + 380);
    chk("np_err2", err, 1);
    chk("np_valid2", valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
